// File: rtl/stopwatch_bcd_ctrl_pkg.sv
// Shared types for the MM:SS stopwatch core: FSM state encoding and the
// four-digit BCD time word used for both the live count and the lap value.
package stopwatch_bcd_ctrl_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [BCD_W-1:0] min_tens;
      logic [BCD_W-1:0] min_ones;
      logic [BCD_W-1:0] sec_tens;
      logic [BCD_W-1:0] sec_ones;
   } bcd_time_t;

endpackage

// File: rtl/stopwatch_bcd_ctrl_if.sv
// Signal bundle between the divider/button side and the stopwatch core.
// There is no valid/ready pairing here: tick_in is a one-cycle strobe that is
// acted on in the cycle it is high, the buttons are raw asynchronous levels,
// and every output is a register value that is valid on every cycle.
interface stopwatch_bcd_ctrl_if;
   import stopwatch_bcd_ctrl_pkg::*;

   logic             tick_in;
   logic             start_stop;
   logic             clear;
   logic             lap;
   logic [BCD_W-1:0] sec_ones;
   logic [BCD_W-1:0] sec_tens;
   logic [BCD_W-1:0] min_ones;
   logic [BCD_W-1:0] min_tens;
   logic             running;
   logic             lap_active;
   logic             overflow;
   state_t           state;      // debug view of the control FSM

   modport master (
      output tick_in, start_stop, clear, lap,
      input  sec_ones, sec_tens, min_ones, min_tens,
      input  running, lap_active, overflow, state
   );

   modport slave (
      input  tick_in, start_stop, clear, lap,
      output sec_ones, sec_tens, min_ones, min_tens,
      output running, lap_active, overflow, state
   );

endinterface

// File: rtl/btn_sync_edge.sv
// Button conditioner: SYNC_STAGES-deep synchroniser followed by a registered
// rising-edge detector. A press gives exactly one pulse SYNC_STAGES+1 cycles
// after the pin rises; holding the button produces nothing further.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   last;

   // Synchronise the pin, remember the previous synced level, emit the rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '0;
         last  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], pin};
         last  <= sync[SYNC_STAGES-1];
         pulse <= sync[SYNC_STAGES-1] & ~last;
      end
   end

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// MM:SS stopwatch core. Conditions the three buttons, runs the IDLE/RUN/PAUSE
// control FSM, advances a BCD seconds/minutes count on divider ticks while
// running, and shows either the live count or a frozen lap value.
module stopwatch_bcd_ctrl
   import stopwatch_bcd_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int MAX_MIN_TENS = 5
) (
   input  logic                 clk10,
   input  logic                 reset,
   stopwatch_bcd_ctrl_if.slave  sw
);

   localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX_MIN_TENS);

   logic      ss_ev;
   logic      clear_ev;
   logic      lap_ev;
   state_t    state;
   logic      running;
   logic      lap_active;
   logic      overflow;
   bcd_time_t live;
   bcd_time_t lap_time;
   bcd_time_t live_inc;
   bcd_time_t shown;
   logic      wrap;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
      .clk(clk10), .reset(reset), .pin(sw.start_stop), .pulse(ss_ev)
   );
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
      .clk(clk10), .reset(reset), .pin(sw.clear), .pulse(clear_ev)
   );
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
      .clk(clk10), .reset(reset), .pin(sw.lap), .pulse(lap_ev)
   );

   // Live count plus one second, rippling carries; wrap flags the full rollover.
   always_comb begin
      live_inc = live;
      wrap     = 1'b0;
      if (live.sec_ones != 4'd9) begin
         live_inc.sec_ones = live.sec_ones + 4'd1;
      end else begin
         live_inc.sec_ones = 4'd0;
         if (live.sec_tens != 4'd5) begin
            live_inc.sec_tens = live.sec_tens + 4'd1;
         end else begin
            live_inc.sec_tens = 4'd0;
            if (live.min_ones != 4'd9) begin
               live_inc.min_ones = live.min_ones + 4'd1;
            end else begin
               live_inc.min_ones = 4'd0;
               if (live.min_tens != MAX_T) begin
                  live_inc.min_tens = live.min_tens + 4'd1;
               end else begin
                  live_inc.min_tens = 4'd0;
                  wrap              = 1'b1;
               end
            end
         end
      end
   end

   // Control FSM with counting and lap capture; decisions use the current state.
   always_ff @(posedge clk10) begin
      if (reset) begin
         state      <= ST_IDLE;
         running    <= 1'b0;
         live       <= '0;
         lap_time   <= '0;
         lap_active <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear_ev) begin
                  live       <= '0;
                  overflow   <= 1'b0;
                  lap_active <= 1'b0;
               end else if (ss_ev) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               // clear is deliberately ignored while running
               if (sw.tick_in) begin
                  live <= live_inc;
                  if (wrap) overflow <= 1'b1;
               end
               if (lap_ev) begin
                  lap_active <= ~lap_active;
                  if (!lap_active) lap_time <= live;
               end
               if (ss_ev) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (clear_ev) begin
                  state      <= ST_IDLE;
                  live       <= '0;
                  overflow   <= 1'b0;
                  lap_active <= 1'b0;
               end else if (ss_ev) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Display selects between registered lap and live values only.
   assign shown         = lap_active ? lap_time : live;
   assign sw.sec_ones   = shown.sec_ones;
   assign sw.sec_tens   = shown.sec_tens;
   assign sw.min_ones   = shown.min_ones;
   assign sw.min_tens   = shown.min_tens;
   assign sw.running    = running;
   assign sw.lap_active = lap_active;
   assign sw.overflow   = overflow;
   assign sw.state      = state;

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// Bench for the stopwatch core: an elapsed-seconds model predicts the outputs
// every cycle, and directed scenarios add literal checks at key points.
module tb_stopwatch_bcd_ctrl;
   import stopwatch_bcd_ctrl_pkg::*;

   localparam int SYNC_STAGES  = 2;
   localparam int MAX_MIN_TENS = 5;
   localparam int LAT          = SYNC_STAGES + 1;
   localparam int W            = 21;
   localparam int MAX_COUNT    = (MAX_MIN_TENS * 10 + 9) * 60 + 59;

   logic clk10;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   check_en = 1'b0;
   logic [W-1:0] exp_q[$];

   stopwatch_bcd_ctrl_if sw();

   stopwatch_bcd_ctrl #(
      .SYNC_STAGES(SYNC_STAGES),
      .MAX_MIN_TENS(MAX_MIN_TENS)
   ) dut (
      .clk10(clk10),
      .reset(reset),
      .sw(sw)
   );

   // clock / reset
   initial begin
      clk10 = 1'b0;
      forever #5 clk10 = ~clk10;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- model: elapsed seconds as a plain integer ----------------
   int          m_live = 0;
   int          m_lap  = 0;
   bit          m_la   = 1'b0;
   bit          m_ov   = 1'b0;
   logic [1:0]  m_st   = ST_IDLE;
   logic [LAT+1:0] h_ss = '0;
   logic [LAT+1:0] h_cl = '0;
   logic [LAT+1:0] h_lp = '0;

   function automatic logic [W-1:0] expect_vec(int shown, bit run, bit la, bit ov,
                                               logic [1:0] st);
      logic [3:0] d3, d2, d1, d0;
      d3 = 4'(shown / 600);
      d2 = 4'((shown / 60) % 10);
      d1 = 4'((shown % 60) / 10);
      d0 = 4'(shown % 10);
      return {d3, d2, d1, d0, run, la, ov, st};
   endfunction

   always @(posedge clk10) begin
      bit e_ss, e_cl, e_lp;
      cyc++;
      if (reset) begin
         m_live = 0; m_lap = 0; m_la = 1'b0; m_ov = 1'b0; m_st = ST_IDLE;
         h_ss = '0; h_cl = '0; h_lp = '0;
      end else begin
         // a press is seen by the FSM LAT edges after the pin is first sampled high
         h_ss = {h_ss[LAT:0], sw.start_stop};
         h_cl = {h_cl[LAT:0], sw.clear};
         h_lp = {h_lp[LAT:0], sw.lap};
         e_ss = h_ss[LAT] & ~h_ss[LAT+1];
         e_cl = h_cl[LAT] & ~h_cl[LAT+1];
         e_lp = h_lp[LAT] & ~h_lp[LAT+1];
         if (m_st == ST_RUN) begin
            if (e_lp) begin
               if (!m_la) m_lap = m_live;
               m_la = !m_la;
            end
            if (sw.tick_in) begin
               if (m_live == MAX_COUNT) begin
                  m_live = 0;
                  m_ov   = 1'b1;
               end else begin
                  m_live = m_live + 1;
               end
            end
            if (e_ss) m_st = ST_PAUSE;
         end else begin
            if (e_cl) begin
               m_st = ST_IDLE; m_live = 0; m_ov = 1'b0; m_la = 1'b0;
            end else if (e_ss) begin
               m_st = ST_RUN;
            end
         end
      end
      exp_q.push_back(expect_vec(m_la ? m_lap : m_live, m_st == ST_RUN, m_la, m_ov, m_st));
   end

   // ---------------- scoreboard: every cycle against the model ----------------
   always @(negedge clk10) begin
      logic [W-1:0] got_v, exp_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         if (check_en) begin
            got_v = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones,
                     sw.running, sw.lap_active, sw.overflow, sw.state};
            n_cmp++;
            if (got_v !== exp_v) begin
               n_bad++;
               $display("FAIL cycle_model cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            end
         end
      end
   end

   // ---------------- driver tasks and literal checks ----------------
   task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   function automatic logic [31:0] digits();
      return {16'h0, sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
   endfunction

   // m[0]=start_stop, m[1]=clear, m[2]=lap; returns after the FSM has reacted
   task automatic press(input logic [2:0] m);
      sw.start_stop = m[0];
      sw.clear      = m[1];
      sw.lap        = m[2];
      repeat (2) @(negedge clk10);
      sw.start_stop = 1'b0;
      sw.clear      = 1'b0;
      sw.lap        = 1'b0;
      repeat (3) @(negedge clk10);
   endtask

   // same press, with tick_in held high for the whole press window
   task automatic press_tick(input logic [2:0] m);
      sw.tick_in = 1'b1;
      press(m);
      sw.tick_in = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         sw.tick_in = 1'b1;
         @(negedge clk10);
         sw.tick_in = 1'b0;
         @(negedge clk10);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      reset         = 1'b1;
      sw.tick_in    = 1'b0;
      sw.start_stop = 1'b0;
      sw.clear      = 1'b0;
      sw.lap        = 1'b0;
      repeat (3) @(negedge clk10);
      check_en = 1'b1;
      check_lit("reset_digits", digits(), 32'h0000);
      check_lit("reset_flags", {29'h0, sw.running, sw.lap_active, sw.overflow}, 32'h0);
      check_lit("reset_state", 32'(sw.state), 32'(ST_IDLE));
      reset = 1'b0;
      @(negedge clk10);

      // tick handling: 75 s -> 01:15
      press(3'b001);
      check_lit("start_running", 32'(sw.running), 32'h1);
      ticks(75);
      check_lit("count_0115", digits(), 32'h0115);

      // simultaneous start_stop+clear in RUN then in PAUSE
      press(3'b011);
      check_lit("simul_run_state", 32'(sw.state), 32'(ST_PAUSE));
      check_lit("simul_run_digits", digits(), 32'h0115);
      press(3'b011);
      check_lit("simul_pause_state", 32'(sw.state), 32'(ST_IDLE));
      check_lit("simul_pause_digits", digits(), 32'h0000);

      // pause and clear
      press(3'b001);
      ticks(7);
      check_lit("count_0007", digits(), 32'h0007);
      press(3'b010);
      check_lit("clear_in_run_digits", digits(), 32'h0007);
      check_lit("clear_in_run_state", 32'(sw.state), 32'(ST_RUN));
      press(3'b001);
      ticks(5);
      check_lit("pause_hold", digits(), 32'h0007);
      press(3'b010);
      check_lit("pause_clear_digits", digits(), 32'h0000);
      check_lit("pause_clear_state", 32'(sw.state), 32'(ST_IDLE));

      // lap freeze and release
      press(3'b001);
      ticks(20);
      press(3'b100);
      check_lit("lap_on", 32'(sw.lap_active), 32'h1);
      ticks(10);
      check_lit("lap_frozen", digits(), 32'h0020);
      press(3'b100);
      check_lit("lap_off_digits", digits(), 32'h0030);
      check_lit("lap_off_flag", 32'(sw.lap_active), 32'h0);

      // ticks across state-change cycles
      press_tick(3'b001);
      check_lit("tick_run_to_pause", digits(), 32'h0034);
      press_tick(3'b001);
      check_lit("tick_pause_to_run", digits(), 32'h0035);
      press(3'b001);
      press(3'b100);
      check_lit("lap_in_pause_ignored", 32'(sw.lap_active), 32'h0);
      press(3'b001);
      press(3'b100);
      press(3'b001);
      check_lit("lap_kept_in_pause", 32'(sw.lap_active), 32'h1);
      check_lit("lap_kept_digits", digits(), 32'h0035);
      press(3'b010);
      check_lit("clear_drops_lap", 32'(sw.lap_active), 32'h0);

      // full wrap
      press(3'b001);
      ticks(MAX_COUNT);
      check_lit("count_5959", digits(), 32'h5959);
      check_lit("no_ovf_yet", 32'(sw.overflow), 32'h0);
      ticks(1);
      check_lit("wrap_digits", digits(), 32'h0000);
      check_lit("wrap_overflow", 32'(sw.overflow), 32'h1);
      ticks(2);
      press(3'b010);
      check_lit("ovf_sticky", 32'(sw.overflow), 32'h1);
      check_lit("count_after_wrap", digits(), 32'h0002);
      press(3'b001);
      press(3'b010);
      check_lit("ovf_cleared", 32'(sw.overflow), 32'h0);

      // reset mid-count
      press(3'b001);
      ticks(221);
      check_lit("count_0341", digits(), 32'h0341);
      sw.tick_in = 1'b1;
      reset      = 1'b1;
      @(negedge clk10);
      sw.tick_in = 1'b0;
      check_lit("midreset_digits", digits(), 32'h0000);
      check_lit("midreset_state", 32'(sw.state), 32'(ST_IDLE));
      check_lit("midreset_running", 32'(sw.running), 32'h0);
      reset = 1'b0;
      @(negedge clk10);

      // held button yields one state change
      sw.start_stop = 1'b1;
      repeat (100) @(negedge clk10);
      check_lit("hold_state", 32'(sw.state), 32'(ST_RUN));
      sw.start_stop = 1'b0;
      repeat (5) @(negedge clk10);
      ticks(3);
      check_lit("hold_count", digits(), 32'h0003);

      repeat (4) @(negedge clk10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
